// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, 8 data bits LSB-first, optional parity, 1 or 2 stop bits.
// Accepts one byte per send_i/ready_o handshake; all outputs are registered.
module uart_tx_serializer #(
    parameter int unsigned BAUD_DIV   = 868,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       send_i,
    input  logic [7:0] data_i,
    output logic       ready_o,
    output logic       tx_o,
    output logic       frame_done_o
);

    localparam int unsigned CntW = $clog2(BAUD_DIV);

    if (BAUD_DIV < 2 || BAUD_DIV > 65535) begin : gen_bad_baud
        $error("uart_tx_serializer: BAUD_DIV must be in 2..65535");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : gen_bad_stop
        $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              parity_q, parity_d;
    logic              stop_cnt_q, stop_cnt_d;
    logic              tx_q, tx_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              bit_end;

    assign bit_end = (cnt_q == CntW'(BAUD_DIV - 1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx_q;
        ready_d    = ready_q;
        done_d     = 1'b0;

        if (state_q != StIdle) begin
            cnt_d = bit_end ? '0 : cnt_q + CntW'(1);
        end

        unique case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (send_i && ready_q) begin
                    shift_d    = data_i;
                    parity_d   = (^data_i) ^ (PARITY_ODD != 0);
                    state_d    = StStart;
                    ready_d    = 1'b0;
                    tx_d       = 1'b0;
                    cnt_d      = '0;
                    bit_idx_d  = '0;
                    stop_cnt_d = 1'b0;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    tx_d    = shift_q[0];
                end
            end
            StData: begin
                if (bit_end) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        if (PARITY_EN != 0) begin
                            state_d = StParity;
                            tx_d    = parity_q;
                        end else begin
                            state_d = StStop;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        // Next data bit is shift_q[1] before the shift lands.
                        tx_d = shift_q[1];
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                    tx_d    = 1'b1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    if (STOP_BITS == 2 && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        state_d    = StIdle;
                        stop_cnt_d = 1'b0;
                        ready_d    = 1'b1;
                        done_d     = 1'b1;
                        tx_d       = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
        end
    end

    assign ready_o      = ready_q;
    assign tx_o         = tx_q;
    assign frame_done_o = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer at BAUD_DIV=4 in three parity/stop configurations.
module tb_uart_tx_serializer;

    localparam int BD = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] data;
    logic       send0, send1, send2;
    logic       ready0, ready1, ready2;
    logic       tx0, tx1, tx2;
    logic       done0, done1, done2;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // dut0: no parity, 1 stop; dut1: odd parity, 2 stop; dut2: even parity, 2 stop
    uart_tx_serializer #(.BAUD_DIV(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .reset_n(reset_n), .send_i(send0), .data_i(data),
        .ready_o(ready0), .tx_o(tx0), .frame_done_o(done0)
    );
    uart_tx_serializer #(.BAUD_DIV(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut1 (
        .clk(clk), .reset_n(reset_n), .send_i(send1), .data_i(data),
        .ready_o(ready1), .tx_o(tx1), .frame_done_o(done1)
    );
    uart_tx_serializer #(.BAUD_DIV(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .send_i(send2), .data_i(data),
        .ready_o(ready2), .tx_o(tx2), .frame_done_o(done2)
    );

    typedef struct {
        int          sel;
        logic [7:0]  data;
        int          nbits;
        logic [11:0] frame;  // frame[0] is the start bit
    } vec_t;

    vec_t vecs[7];

    function automatic logic tx_of(input int sel);
        case (sel)
            0:       return tx0;
            1:       return tx1;
            default: return tx2;
        endcase
    endfunction

    function automatic logic ready_of(input int sel);
        case (sel)
            0:       return ready0;
            1:       return ready1;
            default: return ready2;
        endcase
    endfunction

    function automatic logic done_of(input int sel);
        case (sel)
            0:       return done0;
            1:       return done1;
            default: return done2;
        endcase
    endfunction

    task automatic set_send(input int sel, input logic v);
        case (sel)
            0:       send0 = v;
            1:       send1 = v;
            default: send2 = v;
        endcase
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; returns at the negedge just after accepting edge A.
    task automatic send_frame(input int sel, input logic [7:0] d, input bit hold);
        data = d;
        set_send(sel, 1'b1);
        check_bit($sformatf("dut%0d ready before accept", sel), ready_of(sel), 1'b1);
        @(negedge clk);
        if (!hold) set_send(sel, 1'b0);
    endtask

    // Checks every cycle of the frame; returns at the negedge after edge A+F.
    task automatic run_bits(input int sel, input logic [11:0] frame, input int nbits,
                            input int inject_k);
        for (int k = 0; k < nbits * BD; k++) begin
            check_bit($sformatf("dut%0d tx bit%0d cyc%0d", sel, k / BD, k),
                      tx_of(sel), frame[4'(k / BD)]);
            check_bit($sformatf("dut%0d done low cyc%0d", sel, k), done_of(sel), 1'b0);
            if (k == 0)
                check_bit($sformatf("dut%0d ready drop", sel), ready_of(sel), 1'b0);
            if (k == inject_k) begin
                data = 8'h00;
                set_send(sel, 1'b1);
            end else if (k == inject_k + 1) begin
                set_send(sel, 1'b0);
            end
            @(negedge clk);
        end
    endtask

    task automatic check_end(input int sel);
        check_bit($sformatf("dut%0d ready at A+F", sel), ready_of(sel), 1'b1);
        check_bit($sformatf("dut%0d done at A+F", sel), done_of(sel), 1'b1);
        check_bit($sformatf("dut%0d tx idle at A+F", sel), tx_of(sel), 1'b1);
        @(negedge clk);
        check_bit($sformatf("dut%0d done fall", sel), done_of(sel), 1'b0);
        check_bit($sformatf("dut%0d tx idle after", sel), tx_of(sel), 1'b1);
    endtask

    task automatic check_idle(input int cycles, input string name);
        for (int c = 0; c < cycles; c++) begin
            check_bit($sformatf("%s tx0 c%0d", name, c), tx0, 1'b1);
            check_bit($sformatf("%s ready0 c%0d", name, c), ready0, 1'b1);
            check_bit($sformatf("%s done0 c%0d", name, c), done0, 1'b0);
            @(negedge clk);
        end
    endtask

    initial begin
        // Frames written {stop/pad, parity, data, start}; parity hand-computed.
        vecs[0] = '{0, 8'h55, 10, {2'b00, 1'b1, 8'h55, 1'b0}};
        vecs[1] = '{0, 8'hA3, 10, {2'b00, 1'b1, 8'hA3, 1'b0}};
        vecs[2] = '{1, 8'h07, 12, {2'b11, 1'b0, 8'h07, 1'b0}};
        vecs[3] = '{2, 8'h07, 12, {2'b11, 1'b1, 8'h07, 1'b0}};
        vecs[4] = '{1, 8'h00, 12, {2'b11, 1'b1, 8'h00, 1'b0}};
        vecs[5] = '{2, 8'hFF, 12, {2'b11, 1'b0, 8'hFF, 1'b0}};
        vecs[6] = '{2, 8'h5A, 12, {2'b11, 1'b0, 8'h5A, 1'b0}};

        send0 = 1'b0;
        send1 = 1'b0;
        send2 = 1'b0;
        data  = 8'h00;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        check_bit("reset tx0", tx0, 1'b1);
        check_bit("reset ready0", ready0, 1'b1);
        check_bit("reset done0", done0, 1'b0);
        check_bit("reset tx1", tx1, 1'b1);
        check_bit("reset ready2", ready2, 1'b1);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check_idle(8, "post-reset");

        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i].sel, vecs[i].data, 1'b0);
            run_bits(vecs[i].sel, vecs[i].frame, vecs[i].nbits, -10);
            check_end(vecs[i].sel);
            @(negedge clk);
        end

        // Back-to-back with send held high: exactly one idle cycle between frames.
        send_frame(0, 8'hA3, 1'b1);
        run_bits(0, {2'b00, 1'b1, 8'hA3, 1'b0}, 10, -10);
        check_bit("b2b ready at A+F", ready0, 1'b1);
        check_bit("b2b done at A+F", done0, 1'b1);
        check_bit("b2b gap tx", tx0, 1'b1);
        data = 8'h0F;
        @(negedge clk);
        send0 = 1'b0;
        run_bits(0, {2'b00, 1'b1, 8'h0F, 1'b0}, 10, -10);
        check_end(0);
        @(negedge clk);

        // Busy rejection: a send with 0x00 mid-frame must not alter or follow the 0xFF frame.
        send_frame(0, 8'hFF, 1'b0);
        run_bits(0, {2'b00, 1'b1, 8'hFF, 1'b0}, 10, 10);
        check_end(0);
        check_idle(20, "busy-reject");

        // Reset during data bit 3 (frame index 4, cycles 16..19).
        send_frame(0, 8'h00, 1'b0);
        for (int k = 0; k < 17; k++) @(negedge clk);
        check_bit("pre-reset tx low", tx0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check_bit("mid reset tx0", tx0, 1'b1);
        check_bit("mid reset ready0", ready0, 1'b1);
        check_bit("mid reset done0", done0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check_idle(6, "post-abort");
        send_frame(0, 8'h81, 1'b0);
        run_bits(0, {2'b00, 1'b1, 8'h81, 1'b0}, 10, -10);
        check_end(0);
        check_idle(4, "final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
